rggen_axi4lite_bus_bridge: RTL and testbench

RGGEN_AXI4LITE_BUS_BRIDGE -- requirements
Module: rggen_axi4lite_bus_bridge

---
 rtl/rggen_rtl_pkg.sv | 16 +
 rtl/rggen_axi4lite_if.sv | 46 ++++
 rtl/rggen_axi4lite_bus_bridge.sv | 103 ++++++++++
 tb/tb_rggen_axi4lite_bus_bridge.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_rtl_pkg.sv
// rggen_rtl_pkg: shared bridge FSM state type, bus response codes and width helper.
package rggen_rtl_pkg;
    typedef enum logic [1:0] {
        IDLE,
        BUS_ACCESS,
        RESPONSE
    } rggen_bridge_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    function automatic int rggen_clip_width(input int width);
        return (width > 0) ? width : 1;
    endfunction
endpackage

// File: rtl/rggen_axi4lite_if.sv
// rggen_axi4lite_if: AXI4-Lite channel bundle with master/slave modports.
interface rggen_axi4lite_if
    import rggen_rtl_pkg::*;
#(
    parameter int ID_WIDTH      = 0,
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    localparam int IDW = rggen_clip_width(ID_WIDTH);

    logic                     awvalid;
    logic                     awready;
    logic [IDW-1:0]           awid;
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic                     wvalid;
    logic                     wready;
    logic [BUS_WIDTH-1:0]     wdata;
    logic [BUS_WIDTH/8-1:0]   wstrb;
    logic                     bvalid;
    logic                     bready;
    logic [IDW-1:0]           bid;
    logic [1:0]               bresp;
    logic                     arvalid;
    logic                     arready;
    logic [IDW-1:0]           arid;
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic                     rvalid;
    logic                     rready;
    logic [IDW-1:0]           rid;
    logic [1:0]               rresp;
    logic [BUS_WIDTH-1:0]     rdata;

    modport master (
        output awvalid, awid, awaddr, wvalid, wdata, wstrb, bready,
        output arvalid, arid, araddr, rready,
        input  awready, wready, bvalid, bid, bresp,
        input  arready, rvalid, rid, rresp, rdata
    );

    modport slave (
        input  awvalid, awid, awaddr, wvalid, wdata, wstrb, bready,
        input  arvalid, arid, araddr, rready,
        output awready, wready, bvalid, bid, bresp,
        output arready, rvalid, rid, rresp, rdata
    );
endinterface

// File: rtl/rggen_axi4lite_bus_bridge.sv
// rggen_axi4lite_bus_bridge: AXI4-Lite slave to simple register bus, one transaction in flight.
// Define RGGEN_AXI4LITE_BRIDGE_WRITE_PRIORITY_EN to let writes win simultaneous eligibility.
module rggen_axi4lite_bus_bridge
    import rggen_rtl_pkg::*;
#(
    parameter int ID_WIDTH      = 0,
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
)(
    input  logic                     i_clk,
    input  logic                     i_rst,
    rggen_axi4lite_if.slave          axi4lite_if,
    output logic                     o_bus_valid,
    output logic                     o_bus_write,
    output logic [ADDRESS_WIDTH-1:0] o_bus_address,
    output logic [BUS_WIDTH-1:0]     o_bus_write_data,
    output logic [BUS_WIDTH/8-1:0]   o_bus_strobe,
    input  logic                     i_bus_ready,
    input  logic [1:0]               i_bus_status,
    input  logic [BUS_WIDTH-1:0]     i_bus_read_data
);
    localparam int IDW = rggen_clip_width(ID_WIDTH);
    localparam int LSB = $clog2(BUS_WIDTH / 8);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'((1 << LSB) - 1);

    rggen_bridge_state_e      r_state;
    logic                     r_write;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [BUS_WIDTH-1:0]     r_write_data;
    logic [BUS_WIDTH/8-1:0]   r_strobe;
    logic [IDW-1:0]           r_id;
    logic [1:0]               r_status;
    logic [BUS_WIDTH-1:0]     r_read_data;

    logic w_idle;
    logic w_write_eligible;
    logic w_read_eligible;
    logic w_write_sel;
    logic w_read_sel;
    logic w_accept;
    logic w_response_done;

    assign w_idle           = r_state == IDLE;
    assign w_write_eligible = axi4lite_if.awvalid && axi4lite_if.wvalid;
    assign w_read_eligible  = axi4lite_if.arvalid;
`ifdef RGGEN_AXI4LITE_BRIDGE_WRITE_PRIORITY_EN
    assign w_write_sel = w_write_eligible;
    assign w_read_sel  = w_read_eligible && !w_write_eligible;
`else
    assign w_read_sel  = w_read_eligible;
    assign w_write_sel = w_write_eligible && !w_read_eligible;
`endif
    assign w_accept        = w_idle && (w_write_sel || w_read_sel);
    assign w_response_done = r_write ? axi4lite_if.bready : axi4lite_if.rready;

    assign axi4lite_if.awready = w_idle && w_write_sel;
    assign axi4lite_if.wready  = w_idle && w_write_sel;
    assign axi4lite_if.arready = w_idle && w_read_sel;
    assign axi4lite_if.bvalid  = (r_state == RESPONSE) && r_write;
    assign axi4lite_if.rvalid  = (r_state == RESPONSE) && !r_write;
    assign axi4lite_if.bid     = r_id;
    assign axi4lite_if.rid     = r_id;
    assign axi4lite_if.bresp   = r_status;
    assign axi4lite_if.rresp   = r_status;
    assign axi4lite_if.rdata   = r_read_data;

    assign o_bus_valid      = r_state == BUS_ACCESS;
    assign o_bus_write      = r_write;
    assign o_bus_address    = r_address;
    assign o_bus_write_data = r_write_data;
    assign o_bus_strobe     = r_strobe;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_write      <= 1'b0;
            r_address    <= '0;
            r_write_data <= '0;
            r_strobe     <= '0;
            r_id         <= '0;
            r_status     <= OKAY;
            r_read_data  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_state      <= BUS_ACCESS;
                    r_write      <= w_write_sel;
                    r_address    <= (w_write_sel ? axi4lite_if.awaddr : axi4lite_if.araddr) & ADDR_MASK;
                    r_write_data <= w_write_sel ? axi4lite_if.wdata : '0;
                    r_strobe     <= w_write_sel ? axi4lite_if.wstrb : '1;
                    r_id         <= w_write_sel ? axi4lite_if.awid : axi4lite_if.arid;
                end
                BUS_ACCESS: if (i_bus_ready) begin
                    r_state     <= RESPONSE;
                    r_status    <= i_bus_status;
                    r_read_data <= r_write ? r_read_data : i_bus_read_data;
                end
                RESPONSE: if (w_response_done) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rggen_axi4lite_bus_bridge.sv
// tb_rggen_axi4lite_bus_bridge: directed vector table plus hand-written handshake corner cases.
module tb_rggen_axi4lite_bus_bridge;
    logic        clk;
    logic        rst;
    logic        bus_valid;
    logic        bus_write;
    logic [15:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_strobe;
    logic        bus_ready;
    logic [1:0]  bus_status;
    logic [31:0] bus_read_data;
    int          checks;
    int          errors;
    logic        exp_w;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  id;
        int          rdy_dly;
        logic [1:0]  st;
        logic [31:0] rd;
        int          rsp_dly;
        logic [15:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[4];

    rggen_axi4lite_if #(.ID_WIDTH(2), .ADDRESS_WIDTH(16), .BUS_WIDTH(32)) axi ();

    rggen_axi4lite_bus_bridge #(.ID_WIDTH(2), .ADDRESS_WIDTH(16), .BUS_WIDTH(32)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .axi4lite_if      (axi),
        .o_bus_valid      (bus_valid),
        .o_bus_write      (bus_write),
        .o_bus_address    (bus_address),
        .o_bus_write_data (bus_write_data),
        .o_bus_strobe     (bus_strobe),
        .i_bus_ready      (bus_ready),
        .i_bus_status     (bus_status),
        .i_bus_read_data  (bus_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic finish_txn(input logic [1:0] st, input logic [31:0] rd);
        bus_ready = 1'b1;
        bus_status = st;
        bus_read_data = rd;
        @(negedge clk);
        bus_ready = 1'b0;
        axi.bready = 1'b1;
        axi.rready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        axi.rready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        if (v.wr) begin
            axi.awvalid = 1'b1;
            axi.wvalid = 1'b1;
            axi.awaddr = v.addr;
            axi.wdata = v.wdata;
            axi.wstrb = v.strb;
            axi.awid = v.id;
        end else begin
            axi.arvalid = 1'b1;
            axi.araddr = v.addr;
            axi.arid = v.id;
        end
        #1;
        chk("accept_ready", v.wr ? (axi.awready & axi.wready) : axi.arready, 1);
        @(negedge clk);
        axi.awvalid = 1'b0;
        axi.wvalid = 1'b0;
        axi.arvalid = 1'b0;
        #1;
        chk("req_valid", bus_valid, 1);
        chk("req_write", bus_write, v.wr);
        chk("req_address", bus_address, v.exp_addr);
        chk("req_strobe", bus_strobe, v.exp_strb);
        chk("req_wdata", bus_write_data, v.exp_wdata);
        chk("busy_ready", axi.awready | axi.wready | axi.arready, 0);
        repeat (v.rdy_dly) begin
            @(negedge clk);
            #1;
            chk("hold_valid", bus_valid, 1);
            chk("hold_address", bus_address, v.exp_addr);
            chk("hold_wdata", bus_write_data, v.exp_wdata);
        end
        bus_ready = 1'b1;
        bus_status = v.st;
        bus_read_data = v.rd;
        @(negedge clk);
        bus_ready = 1'b0;
        bus_status = 2'b00;
        bus_read_data = 32'h0;
        #1;
        chk("rsp_bus_valid_off", bus_valid, 0);
        chk("rsp_valid", v.wr ? axi.bvalid : axi.rvalid, 1);
        chk("rsp_other_valid", v.wr ? axi.rvalid : axi.bvalid, 0);
        chk("rsp_code", v.wr ? axi.bresp : axi.rresp, v.st);
        chk("rsp_id", v.wr ? axi.bid : axi.rid, v.id);
        chk("rsp_rdata", axi.rdata, v.exp_rdata);
        repeat (v.rsp_dly) begin
            @(negedge clk);
            #1;
            chk("rsp_hold_valid", v.wr ? axi.bvalid : axi.rvalid, 1);
            chk("rsp_hold_code", v.wr ? axi.bresp : axi.rresp, v.st);
        end
        axi.bready = 1'b1;
        axi.rready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        axi.rready = 1'b0;
        #1;
        chk("rsp_done", axi.bvalid | axi.rvalid, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{1'b1, 16'h0013, 32'hA5A5_5A5A, 4'hF, 2'd0, 1, 2'b00, 32'h0, 0,
                    16'h0010, 4'hF, 32'hA5A5_5A5A, 32'h0};
        vecs[1] = '{1'b0, 16'h0020, 32'h0, 4'h0, 2'd0, 0, 2'b10, 32'h1234_5678, 0,
                    16'h0020, 4'hF, 32'h0, 32'h1234_5678};
        vecs[2] = '{1'b1, 16'h0105, 32'hDEAD_BEEF, 4'h3, 2'd2, 5, 2'b11, 32'hFFFF_FFFF, 3,
                    16'h0104, 4'h3, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[3] = '{1'b0, 16'hFFFF, 32'h0, 4'h0, 2'd1, 2, 2'b00, 32'hCAFE_F00D, 1,
                    16'hFFFC, 4'hF, 32'h0, 32'hCAFE_F00D};
        rst = 1'b1;
        {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready} = '0;
        axi.awaddr = '0;
        axi.araddr = '0;
        axi.wdata = '0;
        axi.wstrb = '0;
        axi.awid = '0;
        axi.arid = '0;
        bus_ready = 1'b0;
        bus_status = 2'b00;
        bus_read_data = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_bus_valid", bus_valid, 0);
        chk("reset_bvalid", axi.bvalid, 0);
        chk("reset_rvalid", axi.rvalid, 0);
        chk("reset_address", bus_address, 0);
        chk("reset_rdata", axi.rdata, 0);
        chk("reset_ready_idle", axi.awready | axi.wready | axi.arready, 0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Read and write eligible together: winner depends on the priority build option.
`ifdef RGGEN_AXI4LITE_BRIDGE_WRITE_PRIORITY_EN
        exp_w = 1'b1;
`else
        exp_w = 1'b0;
`endif
        @(negedge clk);
        axi.arvalid = 1'b1;
        axi.araddr = 16'h0040;
        axi.awvalid = 1'b1;
        axi.wvalid = 1'b1;
        axi.awaddr = 16'h0044;
        axi.wdata = 32'h0BAD_F00D;
        axi.wstrb = 4'hF;
        #1;
        chk("arb_awready", axi.awready, exp_w);
        chk("arb_wready", axi.wready, exp_w);
        chk("arb_arready", axi.arready, !exp_w);
        @(negedge clk);
        if (exp_w) {axi.awvalid, axi.wvalid} = 2'b00;
        else axi.arvalid = 1'b0;
        #1;
        chk("arb_first_write", bus_write, exp_w);
        chk("arb_first_busy", axi.awready | axi.arready, 0);
        bus_ready = 1'b1;
        bus_read_data = 32'h1111_2222;
        @(negedge clk);
        bus_ready = 1'b0;
        #1;
        chk("arb_first_bvalid", axi.bvalid, exp_w);
        chk("arb_first_rvalid", axi.rvalid, !exp_w);
        axi.bready = 1'b1;
        axi.rready = 1'b1;
        #1;
        chk("arb_exit_no_accept", axi.awready | axi.arready, 0);
        @(negedge clk);
        axi.bready = 1'b0;
        axi.rready = 1'b0;
        #1;
        chk("arb_second_awready", axi.awready, !exp_w);
        chk("arb_second_arready", axi.arready, exp_w);
        @(negedge clk);
        {axi.awvalid, axi.wvalid, axi.arvalid} = 3'b000;
        #1;
        chk("arb_second_write", bus_write, !exp_w);
        chk("arb_second_address", bus_address, exp_w ? 16'h0040 : 16'h0044);
        finish_txn(2'b00, 32'h3333_4444);

        // Write address arrives ahead of its data.
        @(negedge clk);
        axi.awvalid = 1'b1;
        axi.awaddr = 16'h0080;
        axi.awid = 2'd3;
        repeat (3) begin
            #1;
            chk("aw_only_awready", axi.awready, 0);
            chk("aw_only_wready", axi.wready, 0);
            @(negedge clk);
        end
        axi.wvalid = 1'b1;
        axi.wdata = 32'h5555_AAAA;
        axi.wstrb = 4'hC;
        #1;
        chk("aw_w_awready", axi.awready, 1);
        chk("aw_w_wready", axi.wready, 1);
        @(negedge clk);
        {axi.awvalid, axi.wvalid} = 2'b00;
        #1;
        chk("aw_w_strobe", bus_strobe, 4'hC);
        finish_txn(2'b00, 32'h0);

        // Reset during the bus access abandons it.
        @(negedge clk);
        axi.awvalid = 1'b1;
        axi.wvalid = 1'b1;
        axi.awaddr = 16'h0200;
        @(negedge clk);
        {axi.awvalid, axi.wvalid} = 2'b00;
        #1;
        chk("mid_rst_valid_before", bus_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_bus_valid", bus_valid, 0);
        chk("mid_rst_bvalid", axi.bvalid, 0);
        chk("mid_rst_rvalid", axi.rvalid, 0);
        chk("mid_rst_rdata", axi.rdata, 0);
        chk("mid_rst_address", bus_address, 0);
        @(negedge clk);
        #1;
        chk("mid_rst_no_late_rsp", axi.bvalid | axi.rvalid | bus_valid, 0);
        run_vec(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
